// File: rtl/dla_pkg.sv
// Shared types and helpers for the DLA partial-sum datapath.
// Pure definitions: no state, no latency, no flow control.
package dla_pkg;
  localparam int HWORD  = 16;
  localparam int TREE_W = HWORD + 4;
  localparam int ACC_W  = 24;
  localparam int CH_W   = 8;

  typedef logic signed [HWORD-1:0]  hword_t;
  typedef hword_t [8:0]             prod_vec_t;
  typedef logic signed [TREE_W-1:0] tree_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Stage payloads; first/last mark a pixel's channel boundaries.
  typedef struct packed {
    tree_t  a, b, c, d, e;
    hword_t bias;
    logic   first;
    logic   last;
  } s1_t;

  typedef struct packed {
    tree_t  a, b, c;
    hword_t bias;
    logic   first;
    logic   last;
  } s2_t;

  typedef struct packed {
    tree_t  sum;
    hword_t bias;
    logic   first;
    logic   last;
  } s3_t;

  function automatic tree_t sext_tree(input hword_t x);
    return {{(TREE_W-HWORD){x[HWORD-1]}}, x};
  endfunction

  function automatic acc_t sext_acc_t(input tree_t x);
    return {{(ACC_W-TREE_W){x[TREE_W-1]}}, x};
  endfunction

  function automatic acc_t sext_acc_h(input hword_t x);
    return {{(ACC_W-HWORD){x[HWORD-1]}}, x};
  endfunction

  // In range when every bit above the result's sign bit matches it.
  function automatic hword_t sat_hword(input acc_t acc);
    if ((&acc[ACC_W-1:HWORD-1]) || !(|acc[ACC_W-1:HWORD-1]))
      return acc[HWORD-1:0];
    else if (acc[ACC_W-1])
      return {1'b1, {(HWORD-1){1'b0}}};
    else
      return {1'b0, {(HWORD-1){1'b1}}};
  endfunction

  function automatic hword_t relu_hword(input hword_t x, input logic en);
    return (en && x[HWORD-1]) ? '0 : x;
  endfunction
endpackage

// File: rtl/dla_tree_stage.sv
// Stall-able register slice for one adder-tree stage (data + valid), 1 cycle.
// Holds everything while i_stall is high; synchronous active-low reset clears it.
module dla_tree_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_stall,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);
  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (!i_stall) begin
      r_vld <= i_vld;
      r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;
endmodule

// File: rtl/dla_psum_tree.sv
// 3x3 product reduction tree + per-pixel channel accumulator with saturating/ReLU output.
// 5-cycle latency from last channel to out_valid; stall freezes every register.
module dla_psum_tree
  import dla_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            in_valid,
  input  prod_vec_t       mul_result_in,
  input  hword_t          bias,
  input  logic [CH_W-1:0] ch_num,
  input  logic            relu_en,
  output hword_t          psum_out,
  output logic            out_valid,
  output logic            busy
);
  logic [CH_W-1:0] r_in_cnt, r_eff_ch, r_ch_cnt;
  logic [CH_W-1:0] w_eff_new, w_eff_ch;
  logic            w_first, w_last;
  s1_t             w_s1_d, w_s1_q;
  s2_t             w_s2_d, w_s2_q;
  s3_t             w_s3_d, w_s3_q;
  logic            w_s1_vld, w_s2_vld, w_s3_vld;
  acc_t            r_acc;
  logic            r_done, r_out_vld;
  hword_t          r_psum;

  // Channel position is resolved at entry so first/last can ride with the data.
  assign w_eff_new = (ch_num == '0) ? CH_W'(1) : ch_num;
  assign w_first   = (r_in_cnt == '0);
  assign w_eff_ch  = w_first ? w_eff_new : r_eff_ch;
  assign w_last    = (r_in_cnt == w_eff_ch - CH_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_cnt <= '0;
      r_eff_ch <= '0;
    end else if (in_valid && !stall) begin
      r_in_cnt <= w_last ? '0 : r_in_cnt + CH_W'(1);
      if (w_first)
        r_eff_ch <= w_eff_new;
    end
  end

  always_comb begin
    w_s1_d       = '0;
    w_s1_d.a     = sext_tree(mul_result_in[0]) + sext_tree(mul_result_in[1]);
    w_s1_d.b     = sext_tree(mul_result_in[2]) + sext_tree(mul_result_in[3]);
    w_s1_d.c     = sext_tree(mul_result_in[4]) + sext_tree(mul_result_in[5]);
    w_s1_d.d     = sext_tree(mul_result_in[6]) + sext_tree(mul_result_in[7]);
    w_s1_d.e     = sext_tree(mul_result_in[8]);
    w_s1_d.bias  = bias;
    w_s1_d.first = w_first;
    w_s1_d.last  = w_last;

    w_s2_d       = '0;
    w_s2_d.a     = w_s1_q.a + w_s1_q.b;
    w_s2_d.b     = w_s1_q.c + w_s1_q.d;
    w_s2_d.c     = w_s1_q.e;
    w_s2_d.bias  = w_s1_q.bias;
    w_s2_d.first = w_s1_q.first;
    w_s2_d.last  = w_s1_q.last;

    w_s3_d       = '0;
    w_s3_d.sum   = w_s2_q.a + w_s2_q.b + w_s2_q.c;
    w_s3_d.bias  = w_s2_q.bias;
    w_s3_d.first = w_s2_q.first;
    w_s3_d.last  = w_s2_q.last;
  end

  dla_tree_stage #(.W($bits(s1_t))) u_s1 (
    .clk(clk), .rst(rst), .i_stall(stall), .i_vld(in_valid),
    .i_dat(w_s1_d), .o_vld(w_s1_vld), .o_dat(w_s1_q)
  );
  dla_tree_stage #(.W($bits(s2_t))) u_s2 (
    .clk(clk), .rst(rst), .i_stall(stall), .i_vld(w_s1_vld),
    .i_dat(w_s2_d), .o_vld(w_s2_vld), .o_dat(w_s2_q)
  );
  dla_tree_stage #(.W($bits(s3_t))) u_s3 (
    .clk(clk), .rst(rst), .i_stall(stall), .i_vld(w_s2_vld),
    .i_dat(w_s3_d), .o_vld(w_s3_vld), .o_dat(w_s3_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc    <= '0;
      r_ch_cnt <= '0;
      r_done   <= 1'b0;
    end else if (!stall) begin
      r_done <= w_s3_vld && w_s3_q.last;
      if (w_s3_vld) begin
        r_acc    <= w_s3_q.first ? sext_acc_t(w_s3_q.sum) + sext_acc_h(w_s3_q.bias)
                                 : r_acc + sext_acc_t(w_s3_q.sum);
        r_ch_cnt <= w_s3_q.last ? '0 : r_ch_cnt + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_psum    <= '0;
      r_out_vld <= 1'b0;
    end else if (!stall) begin
      r_out_vld <= r_done;
      if (r_done)
        r_psum <= relu_hword(sat_hword(r_acc), relu_en);
    end
  end

  assign psum_out  = r_psum;
  assign out_valid = r_out_vld;
  assign busy      = w_s1_vld || w_s2_vld || w_s3_vld || (r_ch_cnt != '0);
endmodule
